// File: rtl/mem_responder.sv
// mem_responder: arbitrates fetch and data ports onto one synchronous SRAM with flush-aware read responses
module mem_responder #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              data_req,
  input  logic              data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_ready,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_rdata,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);
  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt;
  logic pend_f, pend_d, grant_f, grant_d;
  logic [DATA_W-1:0] fetch_hold, data_hold;
  // grant selection, SRAM drive and response muxing; fetch only beats data once it has starved
  always_comb begin
    grant_f = fetch_req & ~flush & (~data_req | (starve_cnt == LIM));
    grant_d = data_req & ~grant_f;
    fetch_ready = grant_f;
    data_ready = grant_d;
    sram_en = grant_f | grant_d;
    sram_we = grant_d & data_we;
    sram_addr = grant_f ? fetch_addr : data_addr;
    sram_wdata = data_wdata;
    fetch_valid = pend_f & ~flush;
    data_valid = pend_d;
    fetch_data = fetch_valid ? sram_rdata : fetch_hold;
    data_rdata = data_valid ? sram_rdata : data_hold;
  end
  // read-pending flags, held output data and the saturating starvation counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_f <= 1'b0;
      pend_d <= 1'b0;
      fetch_hold <= '0;
      data_hold <= '0;
      starve_cnt <= '0;
    end else begin
      pend_f <= grant_f;
      pend_d <= grant_d & ~data_we;
      if (fetch_valid) fetch_hold <= sram_rdata;
      if (data_valid) data_hold <= sram_rdata;
      if (!fetch_req || grant_f) starve_cnt <= '0;
      else if (grant_d && starve_cnt != LIM) starve_cnt <= starve_cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: table-driven cycle vectors plus an asynchronous reset sequence
module tb_mem_responder;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic fetch_req = 1'b0, data_req = 1'b0, data_we = 1'b0;
  logic [15:0] fetch_addr = '0, data_addr = '0, data_wdata = '0;
  logic fetch_ready, fetch_valid, data_ready, data_valid, sram_en, sram_we;
  logic [15:0] fetch_data, data_rdata, sram_addr, sram_wdata, sram_rdata;
  logic [15:0] mem [0:65535];
  int errs = 0, checks = 0;

  typedef struct {
    logic fl, fr;
    logic [15:0] fa;
    logic dr, dw;
    logic [15:0] da, wd;
    logic frdy, drdy, en, we;
    logic [15:0] addr;
    logic fv;
    logic [15:0] fd;
    logic dv;
    logic [15:0] dd;
  } vec_t;
  vec_t vq[$];

  mem_responder dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_ready(data_ready), .data_valid(data_valid), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else sram_rdata <= mem[sram_addr];
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, fr, input logic [15:0] fa, input logic dr, dw, input logic [15:0] da, wd);
    flush = fl; fetch_req = fr; fetch_addr = fa;
    data_req = dr; data_we = dw; data_addr = da; data_wdata = wd;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".fetch_ready"}, 16'(fetch_ready), 16'h0);
    chk({tag, ".data_ready"}, 16'(data_ready), 16'h0);
    chk({tag, ".fetch_valid"}, 16'(fetch_valid), 16'h0);
    chk({tag, ".data_valid"}, 16'(data_valid), 16'h0);
    chk({tag, ".sram_en"}, 16'(sram_en), 16'h0);
    chk({tag, ".sram_we"}, 16'(sram_we), 16'h0);
    chk({tag, ".fetch_data"}, fetch_data, 16'h0);
    chk({tag, ".data_rdata"}, data_rdata, 16'h0);
  endtask

  initial begin
    // fl fr fa      dr dw da       wd      | frdy drdy en we addr    fv fd       dv dd
    vq.push_back('{0,0,16'h0000,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000, 0,16'h0000, 0,16'h0000});
    vq.push_back('{0,0,16'h0000,1,1,16'h0010,16'hBEEF, 0,1,1,1,16'h0010, 0,16'h0000, 0,16'h0000});
    vq.push_back('{0,0,16'h0000,1,1,16'h0020,16'hCAFE, 0,1,1,1,16'h0020, 0,16'h0000, 0,16'h0000});
    vq.push_back('{0,0,16'h0000,1,1,16'h0030,16'h5555, 0,1,1,1,16'h0030, 0,16'h0000, 0,16'h0000});
    vq.push_back('{0,1,16'h0010,0,0,16'h0000,16'h0000, 1,0,1,0,16'h0010, 0,16'h0000, 0,16'h0000});
    vq.push_back('{0,0,16'h0000,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000, 1,16'hBEEF, 0,16'h0000});
    vq.push_back('{0,0,16'h0000,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000, 0,16'hBEEF, 0,16'h0000});
    vq.push_back('{0,0,16'h0000,1,1,16'h0200,16'h1234, 0,1,1,1,16'h0200, 0,16'hBEEF, 0,16'h0000});
    vq.push_back('{0,0,16'h0000,1,0,16'h0200,16'h0000, 0,1,1,0,16'h0200, 0,16'hBEEF, 0,16'h0000});
    vq.push_back('{0,0,16'h0000,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000, 0,16'hBEEF, 1,16'h1234});
    vq.push_back('{0,0,16'h0000,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000, 0,16'hBEEF, 0,16'h1234});
    // contention: four data grants, then fetch, then data again
    for (int i = 0; i < 4; i++)
      vq.push_back('{0,1,16'h0020,1,0,16'h0200,16'h0000, 0,1,1,0,16'h0200, 0,16'hBEEF, i != 0,16'h1234});
    vq.push_back('{0,1,16'h0020,1,0,16'h0200,16'h0000, 1,0,1,0,16'h0020, 0,16'hBEEF, 1,16'h1234});
    vq.push_back('{0,1,16'h0020,1,0,16'h0200,16'h0000, 0,1,1,0,16'h0200, 1,16'hCAFE, 0,16'h1234});
    vq.push_back('{0,0,16'h0000,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000, 0,16'hCAFE, 1,16'h1234});
    // flush in the response cycle squashes the fetch response
    vq.push_back('{0,1,16'h0030,0,0,16'h0000,16'h0000, 1,0,1,0,16'h0030, 0,16'hCAFE, 0,16'h1234});
    vq.push_back('{1,0,16'h0000,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000, 0,16'hCAFE, 0,16'h1234});
    vq.push_back('{0,0,16'h0000,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000, 0,16'hCAFE, 0,16'h1234});
    // flush held with both requests: only data is granted, counter saturates
    for (int i = 0; i < 6; i++)
      vq.push_back('{1,1,16'h0030,1,0,16'h0200,16'h0000, 0,1,1,0,16'h0200, 0,16'hCAFE, i != 0,16'h1234});
    vq.push_back('{1,1,16'h0030,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000, 0,16'hCAFE, 1,16'h1234});
    vq.push_back('{0,1,16'h0030,1,0,16'h0200,16'h0000, 1,0,1,0,16'h0030, 0,16'hCAFE, 0,16'h1234});
    vq.push_back('{0,0,16'h0000,0,0,16'h0000,16'h0000, 0,0,0,0,16'h0000, 1,16'h5555, 0,16'h1234});

    #1 chk_idle("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    foreach (vq[i]) begin
      string t;
      @(negedge clk);
      drive(vq[i].fl, vq[i].fr, vq[i].fa, vq[i].dr, vq[i].dw, vq[i].da, vq[i].wd);
      #2;
      t = $sformatf("row%0d", i);
      chk({t, ".fetch_ready"}, 16'(fetch_ready), 16'(vq[i].frdy));
      chk({t, ".data_ready"}, 16'(data_ready), 16'(vq[i].drdy));
      chk({t, ".sram_en"}, 16'(sram_en), 16'(vq[i].en));
      chk({t, ".sram_we"}, 16'(sram_we), 16'(vq[i].we));
      if (vq[i].en) chk({t, ".sram_addr"}, sram_addr, vq[i].addr);
      if (vq[i].we) chk({t, ".sram_wdata"}, sram_wdata, vq[i].wd);
      chk({t, ".fetch_valid"}, 16'(fetch_valid), 16'(vq[i].fv));
      chk({t, ".fetch_data"}, fetch_data, vq[i].fd);
      chk({t, ".data_valid"}, 16'(data_valid), 16'(vq[i].dv));
      chk({t, ".data_rdata"}, data_rdata, vq[i].dd);
    end

    // asynchronous reset between a fetch handshake and its response
    @(negedge clk);
    drive(0, 1, 16'h0010, 0, 0, 16'h0000, 16'h0000);
    #2 chk("midrst.handshake", 16'(fetch_ready), 16'h1);
    @(posedge clk);
    drive(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    #2 rst = 1'b1;
    #1 chk_idle("midrst");
    @(negedge clk);
    rst = 1'b0;
    #2 chk_idle("post_rst");
    @(negedge clk);
    drive(0, 1, 16'h0020, 1, 0, 16'h0200, 16'h0000);
    #2 chk("post_rst.data_wins", 16'(data_ready), 16'h1);
    chk("post_rst.fetch_blocked", 16'(fetch_ready), 16'h0);
    @(negedge clk);
    drive(0, 1, 16'h0020, 0, 0, 16'h0000, 16'h0000);
    #2 chk("post_rst.fetch_grant", 16'(fetch_ready), 16'h1);
    chk("post_rst.data_valid", 16'(data_valid), 16'h1);
    chk("post_rst.data_rdata", data_rdata, 16'h1234);
    @(negedge clk);
    drive(0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000);
    #2 chk("post_rst.fetch_valid", 16'(fetch_valid), 16'h1);
    chk("post_rst.fetch_data", fetch_data, 16'hCAFE);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
